pulse_seq_nch: RTL and testbench
================================

Name: pulse_seq_nch

Overview:
- Parametrised N-channel optical clock-pulse sequencer. Successor to the fixed 16-channel Pulse/Delay chain.
- Each channel emits one pulse of programmable duration, then waits a programmable delay. Timebase per channel is prescaled by a programmable multiplier.
- Trigger source per channel is selectable: global start, predecessor end, predecessor rise, or off.
- Adds whole-sequence repeat, abort, and a run-time config port. Sits between the UART/RAM config path and the ex_* optical outputs.

Parameters:
- N_CH, 16, number of channels (2..32).
- CNT_W, 16, width of duration/delay counts.
- MULT_W, 5, width of per-channel prescale multiplier.
- REP_W, 8, width of sequence repeat count.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  level; sampled high while idle starts a run.
- abort  in  1  stop all channels immediately.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  $clog2(N_CH)  target channel.
- cfg_field  in  2  0=duration, 1=delay, 2={mode[1:0],mult}, 3=repeat (channel ignored).
- cfg_data  in  CNT_W  write data (LSBs used for fields 2/3).
- ch_out  out  N_CH  pulse outputs.
- ch_end  out  N_CH  per-channel finished flag (level).
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of final repetition.

Behaviour:
- Reset values:
  - Outputs: ch_out=0, ch_end=0, busy=0, done=0.
  - All config is 0: mode OFF, dur=0, del=0, mult=0, repeat=0.
- Config:
  - Write takes effect next cycle.
  - Writes while busy=1 are ignored, with no partial update.
  - cfg_ch >= N_CH is ignored.
- Modes:
  - 0 OFF: never triggers and is excluded from completion.
  - 1 START: triggers in the cycle after start is accepted.
  - 2 CHAIN_END: triggers in the cycle after fin[k-1].
  - 3 CHAIN_RISE: triggers in the same cycle that channel k-1 enters ACTIVE.
  - Channel 0 in mode 2/3 behaves as mode 1.
  - A chain predecessor that is OFF never fires, so its dependents never trigger. The run then never completes; abort is the only exit.
- Unit = mult+1 clocks.
- Channel FSM: IDLE -> ACTIVE -> DONE.
  - IDLE -> ACTIVE on trigger.
  - In ACTIVE, ch_out is high for the first dur*(mult+1) cycles, then low for del*(mult+1) cycles.
  - fin[k] is asserted in the last ACTIVE cycle. The channel then enters DONE and sets ch_end[k].
  - dur=0: ch_out never rises.
  - del=0: fin coincides with the last high cycle.
  - dur=del=0: ACTIVE lasts exactly one cycle, with fin in that cycle and ch_out low.
  - Arithmetic: unit counter is MULT_W bits and phase counter is CNT_W bits. There is no overflow path; maximum phase length is (2^CNT_W-1)*2^MULT_W cycles.
- Example timing: start accepted at cycle 0 (mode 1 channel) gives ch_out high in cycles 1..D*(M+1).
- Top FSM: IDLE -> RUN -> (REPEAT) -> IDLE.
  - start while IDLE: busy=1 next cycle, ch_end cleared, rep_left=repeat.
  - RUN completes when every non-OFF channel is in DONE.
  - If rep_left>0: decrement, clear ch_end, and re-trigger mode-1 channels in the cycle after completion. There are zero idle cycles between repetitions.
  - If rep_left=0: done=1 for one cycle and busy=0 in the same cycle; ch_end stays set.
  - Total runs = repeat+1.
  - All channels OFF: start gives done pulse two cycles later (cycle 1 RUN, cycle 2 done).
- Abort:
  - Next cycle: ch_out=0, all channels IDLE, busy=0, no done pulse, ch_end retains current values.
  - abort and start in the same cycle: abort wins and start is ignored.
  - rst mid-run: behaves as abort and additionally clears config and ch_end.
- start held high continuously re-arms a new run on the cycle after done.

Decomposition:
- Shared package pulse_seq_pkg:
  - mode encodings MODE_OFF/START/CHAIN_END/CHAIN_RISE;
  - cfg_field codes;
  - channel FSM state typedef;
  - top FSM state typedef.
- One sub-module pulse_seq_ch holds a single channel's config regs, prescaler, phase counter and FSM; it is instantiated N_CH times via generate.
- The top module holds the config decode, chain wiring, completion AND-reduce, and repeat logic.

Test Plan:
- ch0 mode1 dur=3 del=2 mult=0, others OFF; start at cycle 0 -> ch_out[0] high cycles 1-3; done at cycle 6.
- ch0 mode1 dur=2 del=1 mult=1; ch1 mode2 dur=1 del=0 mult=0 -> ch_out[0] high 1-4, ch_out[1] high at cycle 7 only; done at cycle 8.
- ch1 mode3 with ch0 mode1 dur=4 -> ch_out[1] rises in cycle 1, same as ch_out[0]; dur=0/del=0 channel shows one-cycle fin, ch_out stays low.
- repeat=2 with single channel dur=1 del=1 -> three pulses at cycles 1, 3, 5; exactly one done pulse; a config write mid-run leaves values unchanged on readback (behavioural check).
- abort in cycle 2 of a 10-cycle pulse -> ch_out=0 and busy=0 at cycle 3, no done; start+abort in the same cycle -> no run.
- N_CH=4, CNT_W=8 rerun of scenario 2; all-OFF start -> done at cycle 2; rst mid-run -> all outputs 0 next cycle and config reads as zero behaviour.

Source files
------------

// File: rtl/pulse_seq_pkg.sv
// Shared encodings for the N-channel pulse sequencer: trigger modes, config
// field codes and the channel / top-level FSM state types.
package pulse_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF        = 2'd0,
    MODE_START      = 2'd1,
    MODE_CHAIN_END  = 2'd2,
    MODE_CHAIN_RISE = 2'd3
  } mode_e;

  localparam logic [1:0] FIELD_DUR    = 2'd0;
  localparam logic [1:0] FIELD_DEL    = 2'd1;
  localparam logic [1:0] FIELD_MODE   = 2'd2;
  localparam logic [1:0] FIELD_REPEAT = 2'd3;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_ACTIVE,
    CH_DONE
  } ch_state_e;

  typedef enum logic {
    TOP_IDLE,
    TOP_RUN
  } top_state_e;

endpackage

// File: rtl/pulse_seq_ch.sv
// One sequencer channel: config registers, prescaler, phase counter and the
// IDLE -> ACTIVE -> DONE state machine. fin_o marks the last ACTIVE cycle.
module pulse_seq_ch
  import pulse_seq_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int MULT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we_i,
  input  logic [1:0]       cfg_field_i,
  input  logic [CNT_W-1:0] cfg_data_i,
  input  logic             trig_i,
  input  logic             clear_i,
  input  logic             abort_i,
  output mode_e            mode_o,
  output logic             fin_o,
  output logic             done_o,
  output logic             ch_out_o,
  output logic             ch_end_o
);

  mode_e             mode_q;
  logic [MULT_W-1:0] mult_q;
  logic [CNT_W-1:0]  dur_q, del_q;

  ch_state_e         state_q, state_d;
  logic              high_q, high_d;
  logic [MULT_W-1:0] unit_q, unit_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              end_q, end_d;

  logic [CNT_W-1:0]  lim;
  logic              active, last_unit, phase_end;

  // NOTE: config registers sit on the synchronous reset too, so rst returns every channel to OFF.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_OFF;
      mult_q <= '0;
      dur_q  <= '0;
      del_q  <= '0;
    end else if (cfg_we_i) begin
      case (cfg_field_i)
        FIELD_DUR:  dur_q <= cfg_data_i;
        FIELD_DEL:  del_q <= cfg_data_i;
        FIELD_MODE: begin
          mult_q <= cfg_data_i[MULT_W-1:0];
          mode_q <= mode_e'(cfg_data_i[MULT_W+1:MULT_W]);
        end
        default: ;
      endcase
    end
  end

  assign active    = (state_q == CH_ACTIVE);
  assign lim       = high_q ? dur_q : del_q;
  assign last_unit = (unit_q == mult_q);
  assign phase_end = (lim == '0) || (last_unit && (cnt_q == lim - CNT_W'(1)));
  assign fin_o     = active && phase_end && (!high_q || (del_q == '0));

  // NOTE: every _d takes its hold value first so the decode below can never infer a latch.
  always_comb begin
    state_d = state_q;
    high_d  = high_q;
    unit_d  = unit_q;
    cnt_d   = cnt_q;
    end_d   = end_q;
    if (active) begin
      if (fin_o) begin
        state_d = CH_DONE;
        end_d   = 1'b1;
      end else if (phase_end) begin
        high_d = 1'b0;
        unit_d = '0;
        cnt_d  = '0;
      end else if (last_unit) begin
        unit_d = '0;
        cnt_d  = cnt_q + CNT_W'(1);
      end else begin
        unit_d = unit_q + MULT_W'(1);
      end
    end
    // Priority: abort over trigger over clear over normal sequencing.
    if (clear_i) begin
      state_d = CH_IDLE;
      end_d   = 1'b0;
    end
    if (trig_i) begin
      state_d = CH_ACTIVE;
      high_d  = (dur_q != '0);
      unit_d  = '0;
      cnt_d   = '0;
    end
    if (abort_i) begin
      state_d = CH_IDLE;
      end_d   = end_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CH_IDLE;
      high_q  <= 1'b0;
      unit_q  <= '0;
      cnt_q   <= '0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      high_q  <= high_d;
      unit_q  <= unit_d;
      cnt_q   <= cnt_d;
      end_q   <= end_d;
    end
  end

  assign mode_o   = mode_q;
  assign done_o   = (state_q == CH_DONE);
  assign ch_out_o = active && high_q;
  assign ch_end_o = end_q;

endmodule

// File: rtl/pulse_seq_nch.sv
// N-channel pulse sequencer top: config decode, trigger chain wiring,
// completion detection and whole-sequence repeat / abort control.
module pulse_seq_nch
  import pulse_seq_pkg::*;
#(
  parameter int N_CH   = 16,
  parameter int CNT_W  = 16,
  parameter int MULT_W = 5,
  parameter int REP_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    cfg_we,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [1:0]              cfg_field,
  input  logic [CNT_W-1:0]        cfg_data,
  output logic [N_CH-1:0]         ch_out,
  output logic [N_CH-1:0]         ch_end,
  output logic                    busy,
  output logic                    done
);

  localparam int CH_W = $clog2(N_CH);

  top_state_e       state_q, state_d;
  logic [REP_W-1:0] repeat_q, rep_left_q, rep_left_d;
  logic             done_q, done_d;

  logic             cfg_ok, start_acc, complete, run_end, restart, go;
  logic             prev_trig, prev_fin;
  logic [N_CH-1:0]  ch_we, trig, ch_fin, ch_done;
  mode_e            ch_mode [N_CH];

  assign busy      = (state_q == TOP_RUN);
  assign done      = done_q;
  assign cfg_ok    = cfg_we && !busy;
  assign start_acc = (state_q == TOP_IDLE) && start && !abort;
  assign run_end   = busy && complete && !abort;
  assign restart   = run_end && (rep_left_q != '0);
  assign go        = start_acc || restart;

  // An out-of-range cfg_ch matches no k and is dropped.
  always_comb begin
    ch_we    = '0;
    complete = 1'b1;
    for (int k = 0; k < N_CH; k++) begin
      ch_we[k] = cfg_ok && (cfg_field != FIELD_REPEAT) && (cfg_ch == CH_W'(k));
      complete = complete && ((ch_mode[k] == MODE_OFF) || ch_done[k] || ch_fin[k]);
    end
  end

  // Chain triggers ripple from channel 0 upward; channel 0 treats chain modes as START.
  always_comb begin
    trig      = '0;
    prev_trig = 1'b0;
    prev_fin  = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      case (ch_mode[k])
        MODE_START:      trig[k] = go;
        MODE_CHAIN_END:  trig[k] = (k == 0) ? go : prev_fin;
        MODE_CHAIN_RISE: trig[k] = (k == 0) ? go : prev_trig;
        default:         trig[k] = 1'b0;
      endcase
      prev_trig = trig[k];
      prev_fin  = ch_fin[k];
    end
  end

  always_comb begin
    state_d    = state_q;
    rep_left_d = rep_left_q;
    done_d     = 1'b0;
    if (abort) begin
      state_d = TOP_IDLE;
    end else if (start_acc) begin
      state_d    = TOP_RUN;
      rep_left_d = repeat_q;
    end else if (restart) begin
      rep_left_d = rep_left_q - REP_W'(1);
    end else if (run_end) begin
      state_d = TOP_IDLE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TOP_IDLE;
      repeat_q   <= '0;
      rep_left_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rep_left_q <= rep_left_d;
      done_q     <= done_d;
      if (cfg_ok && (cfg_field == FIELD_REPEAT)) repeat_q <= cfg_data[REP_W-1:0];
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    pulse_seq_ch #(
      .CNT_W (CNT_W),
      .MULT_W(MULT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .cfg_we_i   (ch_we[k]),
      .cfg_field_i(cfg_field),
      .cfg_data_i (cfg_data),
      .trig_i     (trig[k]),
      .clear_i    (go),
      .abort_i    (abort),
      .mode_o     (ch_mode[k]),
      .fin_o      (ch_fin[k]),
      .done_o     (ch_done[k]),
      .ch_out_o   (ch_out[k]),
      .ch_end_o   (ch_end[k])
    );
  end

endmodule

// File: tb/tb_pulse_seq_nch.sv
// Scoreboard bench: a 16-channel and a 4-channel/8-bit sequencer share stimulus;
// per-cycle expectations are queued per scenario and popped as the cycles elapse.
module tb_pulse_seq_nch;

  logic        clk = 1'b0;
  logic        rst, start, abort, cfg_we;
  logic [3:0]  cfg_ch;
  logic [1:0]  cfg_field;
  logic [15:0] cfg_data;
  logic [15:0] ch_out_b, ch_end_b;
  logic        busy_b, done_b;
  logic [3:0]  ch_out_s, ch_end_s;
  logic        busy_s, done_s;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [2:0] out;
    logic [2:0] ende;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] e_out [3];
  logic [63:0] e_end [3];
  logic [63:0] e_busy, e_done;

  always #5 clk = ~clk;

  pulse_seq_nch u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_field(cfg_field),
    .cfg_data (cfg_data),
    .ch_out   (ch_out_b),
    .ch_end   (ch_end_b),
    .busy     (busy_b),
    .done     (done_b)
  );

  pulse_seq_nch #(.N_CH(4), .CNT_W(8)) u_dut_s (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch[1:0]),
    .cfg_field(cfg_field),
    .cfg_data (cfg_data[7:0]),
    .ch_out   (ch_out_s),
    .ch_end   (ch_end_s),
    .busy     (busy_s),
    .done     (done_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Called and returns #1 after a rising edge.
  task automatic cfg_write(input int ch, input logic [1:0] field, input int data);
    cfg_we    = 1'b1;
    cfg_ch    = 4'(ch);
    cfg_field = field;
    cfg_data  = 16'(data);
    @(posedge clk); #1;
    cfg_we    = 1'b0;
  endtask

  task automatic set_mode(input int ch, input int mode, input int mult);
    cfg_write(ch, 2'd2, mode * 32 + mult);
  endtask

  task automatic set_ch(input int ch, input int mode, input int dur, input int del, input int mult);
    cfg_write(ch, 2'd0, dur);
    cfg_write(ch, 2'd1, del);
    set_mode(ch, mode, mult);
  endtask

  task automatic exp_clear();
    for (int k = 0; k < 3; k++) begin
      e_out[k] = '0;
      e_end[k] = '0;
    end
    e_busy = '0;
    e_done = '0;
  endtask

  // Cycle 0 is the cycle in which start is first presented.
  task automatic run_scn(input string tag, input int ncyc, input int start_last,
                         input int abort_c, input int rst_c, input int wr_c);
    exp_t e;
    for (int c = 1; c <= ncyc; c++) begin
      e.out  = {e_out[2][c], e_out[1][c], e_out[0][c]};
      e.ende = {e_end[2][c], e_end[1][c], e_end[0][c]};
      e.busy = e_busy[c];
      e.done = e_done[c];
      sb.push_back(e);
    end
    for (int c = 0; c <= ncyc; c++) begin
      start     = (c <= start_last);
      abort     = (c == abort_c);
      rst       = (c == rst_c);
      cfg_we    = (c == wr_c);
      cfg_ch    = 4'd0;
      cfg_field = 2'd0;
      cfg_data  = 16'd5;
      @(negedge clk);
      if (c >= 1 && sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("%s c%0d big.ch_out", tag, c), 32'(ch_out_b), 32'(e.out));
        check($sformatf("%s c%0d big.ch_end", tag, c), 32'(ch_end_b), 32'(e.ende));
        check($sformatf("%s c%0d big.busy", tag, c), 32'(busy_b), 32'(e.busy));
        check($sformatf("%s c%0d big.done", tag, c), 32'(done_b), 32'(e.done));
        check($sformatf("%s c%0d small.ch_out", tag, c), 32'(ch_out_s), 32'(e.out));
        check($sformatf("%s c%0d small.ch_end", tag, c), 32'(ch_end_s), 32'(e.ende));
        check($sformatf("%s c%0d small.busy", tag, c), 32'(busy_s), 32'(e.busy));
        check($sformatf("%s c%0d small.done", tag, c), 32'(done_s), 32'(e.done));
      end
      @(posedge clk); #1;
    end
    start  = 1'b0;
    abort  = 1'b0;
    rst    = 1'b0;
    cfg_we = 1'b0;
    check($sformatf("%s scoreboard drained", tag), 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_field = '0; cfg_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset big.ch_out", 32'(ch_out_b), 32'd0);
    check("reset big.ch_end", 32'(ch_end_b), 32'd0);
    check("reset big.busy", 32'(busy_b), 32'd0);
    check("reset big.done", 32'(done_b), 32'd0);
    check("reset small.ch_out", 32'(ch_out_s), 32'd0);
    check("reset small.ch_end", 32'(ch_end_s), 32'd0);
    check("reset small.busy", 32'(busy_s), 32'd0);
    check("reset small.done", 32'(done_s), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single channel: high 1-3, low 4-5, done at 6.
    set_ch(0, 1, 3, 2, 0);
    exp_clear();
    e_out[0] = span(1, 3); e_end[0] = span(6, 63);
    e_busy = span(1, 5); e_done = span(6, 6);
    run_scn("single", 9, 0, -1, -1, -1);

    // Prescaled ch0 then chain-end ch1.
    set_ch(0, 1, 2, 1, 1);
    set_ch(1, 2, 1, 0, 0);
    exp_clear();
    e_out[0] = span(1, 4); e_out[1] = span(7, 7);
    e_end[0] = span(7, 63); e_end[1] = span(8, 63);
    e_busy = span(1, 7); e_done = span(8, 8);
    run_scn("chain_end", 10, 0, -1, -1, -1);

    // Chain-rise ch1 alongside ch0; ch2 has dur=del=0 (one-cycle fin, no pulse).
    set_ch(0, 1, 4, 0, 0);
    set_ch(1, 3, 2, 0, 0);
    set_ch(2, 1, 0, 0, 0);
    exp_clear();
    e_out[0] = span(1, 4); e_out[1] = span(1, 2);
    e_end[0] = span(5, 63); e_end[1] = span(3, 63); e_end[2] = span(2, 63);
    e_busy = span(1, 4); e_done = span(5, 5);
    run_scn("chain_rise", 7, 0, -1, -1, -1);

    // Repeat=2: pulses at 1,3,5; a dur write during the run must be ignored.
    set_mode(1, 0, 0);
    set_mode(2, 0, 0);
    set_ch(0, 1, 1, 1, 0);
    cfg_write(0, 2'd3, 2);
    exp_clear();
    e_out[0] = span(1, 1) | span(3, 3) | span(5, 5);
    e_end[0] = span(7, 63);
    e_busy = span(1, 6); e_done = span(7, 7);
    run_scn("repeat_wr", 9, 0, -1, -1, 2);
    run_scn("repeat_again", 9, 0, -1, -1, -1);

    // Abort in cycle 2 of a 10-cycle pulse; ch2 ch_end survives the abort.
    set_ch(0, 1, 10, 0, 0);
    set_mode(2, 1, 0);
    cfg_write(0, 2'd3, 0);
    exp_clear();
    e_out[0] = span(1, 2); e_end[2] = span(2, 63);
    e_busy = span(1, 2);
    run_scn("abort", 14, 0, 2, -1, -1);

    // start and abort together: nothing starts, ch_end untouched.
    exp_clear();
    e_end[2] = span(1, 63);
    run_scn("start_abort", 6, 0, 0, -1, -1);

    // All OFF with start held: done two cycles after each accepted start.
    set_mode(0, 0, 0);
    set_mode(2, 0, 0);
    exp_clear();
    e_busy = span(1, 1) | span(3, 3); e_done = span(2, 2) | span(4, 4);
    run_scn("all_off_held", 6, 2, -1, -1, -1);

    // rst mid-run clears outputs, ch_end and config.
    set_mode(0, 1, 0);
    set_mode(2, 1, 0);
    exp_clear();
    e_out[0] = span(1, 2); e_end[2] = span(2, 2);
    e_busy = span(1, 2);
    run_scn("rst_mid", 6, 0, -1, 2, -1);

    exp_clear();
    e_busy = span(1, 1); e_done = span(2, 2);
    run_scn("after_rst", 4, 0, -1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
